// File: rtl/subtrator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : subtrator                                                       |
// | Purpose  : Registered unsigned subtractor. Computes (a - b) mod 2^WIDTH    |
// |            and a borrow-out flag through a ripple borrow chain, capturing  |
// |            both on the rising clock edge (1-cycle latency, 1/cycle rate).  |
// |            WIDTH=1 is a clocked half subtractor.                           |
// | Ports    : clk  - rising-edge clock                                        |
// |            rst  - synchronous reset, active-high; clears s and c           |
// |            a    - minuend, unsigned, WIDTH bits                            |
// |            b    - subtrahend, unsigned, WIDTH bits                         |
// |            c    - registered borrow-out (1 when a < b)                     |
// |            s    - registered difference, WIDTH bits                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module subtrator #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             c,
  output logic [WIDTH-1:0] s
);

  // Per-bit difference and borrow-out of the ripple chain.
  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] borrow_d;

  logic [WIDTH-1:0] s_q;
  logic             c_q;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i = i + 1) begin : g_bit
      if (i == 0) begin : g_half
        // LSB has no borrow-in, so a half subtractor suffices.
        assign diff_d[i]   = a[i] ^ b[i];
        assign borrow_d[i] = ~a[i] & b[i];
      end else begin : g_full
        // Borrow out when this bit alone needs one, or when the bits are
        // equal and the lower stage already borrowed.
        assign diff_d[i]   = a[i] ^ b[i] ^ borrow_d[i-1];
        assign borrow_d[i] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow_d[i-1]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else begin
      s_q <= diff_d;
      c_q <= borrow_d[WIDTH-1];
    end
  end

  assign s = s_q;
  assign c = c_q;

endmodule
`default_nettype wire

// File: tb/tb_subtrator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_subtrator                                                    |
// | Purpose  : Self-checking bench for subtrator at WIDTH = 1, 4 and 8. All    |
// |            three instances share one clock and reset; every edge checks    |
// |            each instance against an arithmetic reference model.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_subtrator;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       c1, c4, c8;
  logic [0:0] s1;
  logic [3:0] s4;
  logic [7:0] s8;

  int vectors     = 0;
  int miscompares = 0;
  int step_no     = 0;

  always #5 clk = ~clk;

  subtrator #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .s(s1));
  subtrator #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .s(s4));
  subtrator #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .s(s8));

  // Reference: plain integer subtraction folded into [0, 2^w), borrow by compare.
  // Result packed as {c, s[7:0]}.
  function automatic logic [8:0] model(input int w, input logic r, input int av, input int bv);
    int m;
    int d;
    logic [8:0] res;
    if (r) return 9'd0;
    m = 1 << w;
    d = ((av - bv) % m + m) % m;
    res[7:0] = d[7:0];
    res[8]   = (av < bv);
    return res;
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s step=%0d observed c/s=%h expected c/s=%h", tag, step_no, obs, exp);
    end
  endtask

  // Drive one operand set away from the active edge, clock it in, then check
  // every instance one edge later against the model of what was driven.
  task automatic step(input logic r, input int ia1, input int ib1,
                      input int ia4, input int ib4, input int ia8, input int ib8);
    @(negedge clk);
    rst = r;
    a1 = ia1[0:0]; b1 = ib1[0:0];
    a4 = ia4[3:0]; b4 = ib4[3:0];
    a8 = ia8[7:0]; b8 = ib8[7:0];
    @(posedge clk);
    #1;
    step_no++;
    check("w1", {c1, 7'd0, s1}, model(1, r, ia1 & 1, ib1 & 1));
    check("w4", {c4, 4'd0, s4}, model(4, r, ia4 & 15, ib4 & 15));
    check("w8", {c8, s8},       model(8, r, ia8 & 255, ib8 & 255));
  endtask

  initial begin
    rst = 1'b1;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;

    // Reset with a=b=1 must give zeros; then equal operands give zero.
    step(1'b1, 1, 1, 1, 1, 1, 1);
    step(1'b0, 1, 1, 1, 1, 1, 1);

    // WIDTH=1 truth table, alongside WIDTH=4 directed cases.
    step(1'b0, 0, 0, 3, 5, 0, 0);
    step(1'b0, 0, 1, 9, 4, 0, 255);
    step(1'b0, 1, 0, 0, 15, 255, 0);
    step(1'b0, 1, 1, 7, 7, 200, 200);

    // Back-to-back operand changes every cycle.
    step(1'b0, 0, 1, 15, 0, 0, 1);
    step(1'b0, 1, 0, 0, 1, 128, 127);
    step(1'b0, 0, 1, 8, 9, 127, 128);

    // Reset in mid-stream with steady a=0, b=1; no stale result afterwards.
    step(1'b0, 0, 1, 0, 1, 0, 1);
    step(1'b1, 0, 1, 0, 1, 0, 1);
    step(1'b0, 0, 1, 0, 1, 0, 1);

    // Randomized operands, with occasional reset edges.
    for (int n = 0; n < 1000; n++) begin
      step(($urandom_range(0, 31) == 0),
           int'($urandom_range(0, 1)),   int'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)),  int'($urandom_range(0, 15)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
